// File: rtl/pipelined_fetch.sv
// Instruction fetch stage. It issues one memory read per cycle while the
// decoupling queue has credit, pushes each returned word together with its
// PC, and presents the head of the queue to decode. A redirect, such as a
// taken branch or a flush, restarts fetch at a word-aligned target and
// drops everything queued or in flight.
module pipelined_fetch #(
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       DEPTH    = 4,   // power of 2, at least 2
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]         imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned       PTR_W      = $clog2(DEPTH);
    localparam int unsigned       CNT_W      = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INSTR_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(PC_STEP - ADDR_W'(1));

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

    logic               pop;
    logic               push;
    logic [CNT_W:0]     occupancy;

    // Handshakes and credit check. In-flight returns count against the
    // queue capacity, so the queue cannot overflow. A pop in the same
    // cycle frees one slot, which allows one word per cycle at DEPTH=2.
    always_comb begin
        out_valid = (count_q != '0) & ~redirect & ~reset;
        pop       = out_valid & out_ready;
        push      = inflight_q & ~redirect & ~reset;
        occupancy = {1'b0, count_q}
                  + {{CNT_W{1'b0}}, inflight_q}
                  - {{CNT_W{1'b0}}, pop};
        imem_req  = ~reset & ~redirect & (occupancy < (CNT_W + 1)'(DEPTH));
    end

    assign imem_addr = pc_q;
    assign out_instr = instr_mem_q[rd_ptr_q];
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign count     = count_q;

    // Next-state logic. Priority: reset, then redirect, then normal fetch and queue traffic.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (reset) begin
            pc_d     = RESET_PC;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (redirect) begin
            pc_d     = redirect_pc & ALIGN_MASK;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            inflight_d = imem_req;
            if (imem_req) begin
                pc_d          = pc_q + PC_STEP;
                inflight_pc_d = pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage. It has no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_pipelined_fetch.sv
// Testbench for pipelined_fetch. The scoreboard holds the PC stream that
// decode should see. It restarts on reset and on every redirect, and each
// pop must match the front of the stream.
module tb_pipelined_fetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  count;

    logic        reset2 = 1'b1;
    logic        imem_req2;
    logic [15:0] imem_addr2;
    logic [31:0] imem_rdata2 = '0;
    logic        out_valid2;
    logic [31:0] out_instr2;
    logic [15:0] out_pc2;
    logic [1:0]  count2;

    pipelined_fetch #(.ADDR_W(64), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .count(count)
    );

    pipelined_fetch #(.ADDR_W(16), .INSTR_W(32), .DEPTH(2), .RESET_PC(16'hFFFC)) dut_wrap (
        .clk(clk), .reset(reset2), .redirect(1'b0), .redirect_pc(16'h0),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .out_valid(out_valid2), .out_ready(1'b1), .out_instr(out_instr2),
        .out_pc(out_pc2), .count(count2)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    // Instruction memory: returns data one cycle after each accepted request.
    always @(posedge clk) begin
        if (imem_req)  imem_rdata  <= mem_word(imem_addr);
        if (imem_req2) imem_rdata2 <= mem_word({48'h0, imem_addr2});
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [63:0] exp_q [$];
    logic [63:0] e;

    task automatic start_stream(input logic [63:0] base);
        exp_q.delete();
        for (int i = 0; i < 512; i++) exp_q.push_back(base + 64'(4 * i));
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            start_stream(64'h0);
        end else if (redirect) begin
            check("redirect_no_valid", out_valid, 1'b0);
            start_stream(redirect_pc & ~64'h3);
        end else if (out_valid && out_ready) begin
            check("sb_avail", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_pc", out_pc, e);
                check("out_instr", out_instr, mem_word(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] wexp [4] = '{16'hFFFC, 16'h0000, 16'h0004, 16'h0008};

    initial begin
        int k;
        int idx;
        logic [63:0] held;

        // Reset state
        reset = 1'b1; out_ready = 1'b1;
        repeat (3) tick();
        #1;
        check("reset_count", count, 0);
        check("reset_valid", out_valid, 0);
        check("reset_req", imem_req, 0);
        check("reset_addr", imem_addr, 64'h0);

        // Release: first request at RESET_PC, first output two cycles later
        reset = 1'b0; #1;
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 64'h0);
        tick(); #1;
        check("lat_n1_valid", out_valid, 0);
        tick(); #1;
        check("lat_n2_valid", out_valid, 1);
        check("lat_n2_pc", out_pc, 64'h0);
        for (int i = 0; i < 16; i++) begin
            tick(); #1;
            check("stream_valid", out_valid, 1);
            check("stream_count", count, 1);
        end

        // Stall: queue saturates, head holds, request stops
        tick(); out_ready = 1'b0; #1;
        held = out_pc;
        repeat (10) begin
            tick(); #1;
            check("stall_pc_hold", out_pc, held);
        end
        check("stall_count_full", count, DEPTH);
        check("stall_req_off", imem_req, 0);
        check("stall_valid", out_valid, 1);
        tick(); out_ready = 1'b1; #1;
        check("resume_req", imem_req, 1);
        check("drain_valid", out_valid, 1);
        for (int i = 0; i < DEPTH + 4; i++) begin
            tick(); #1;
            check("drain_valid", out_valid, 1);
        end

        // Redirect to 0x103 with three entries queued
        tick(); out_ready = 1'b0; #1;
        k = 0;
        while (count != 3 && k < 10) begin tick(); #1; k++; end
        check("fill3_count", count, 3);
        redirect = 1'b1; redirect_pc = 64'h103; out_ready = 1'b1; #1;
        check("redir_valid", out_valid, 0);
        tick(); redirect = 1'b0; #1;
        check("redir_count", count, 0);
        check("redir_addr", imem_addr, 64'h100);
        check("redir_req", imem_req, 1);
        tick(); #1;
        check("redir_lat1_valid", out_valid, 0);
        tick(); #1;
        check("redir_first_valid", out_valid, 1);
        check("redir_first_pc", out_pc, 64'h100);
        repeat (6) tick();

        // Redirect in the return cycle, then a second redirect
        #1;
        check("pre_req", imem_req, 1);
        tick(); redirect = 1'b1; redirect_pc = 64'h2000; #1;
        check("r1_req", imem_req, 0);
        tick(); redirect_pc = 64'h3000; #1;
        check("r2_addr_prev", imem_addr, 64'h2000);
        check("r2_count", count, 0);
        tick(); redirect = 1'b0; #1;
        check("r2_addr", imem_addr, 64'h3000);
        check("r2_count_after", count, 0);
        tick(); #1;
        check("r2_lat1_valid", out_valid, 0);
        tick(); #1;
        check("r2_first_valid", out_valid, 1);
        check("r2_first_pc", out_pc, 64'h3000);
        repeat (4) tick();

        // Reset while full with redirect asserted
        out_ready = 1'b0; #1;
        k = 0;
        while (count != DEPTH && k < 12) begin tick(); #1; k++; end
        check("full_before_reset", count, DEPTH);
        reset = 1'b1; redirect = 1'b1; redirect_pc = 64'h5000; #1;
        check("rst_req", imem_req, 0);
        check("rst_valid", out_valid, 0);
        tick(); reset = 1'b0; redirect = 1'b0; #1;
        check("rst_count", count, 0);
        check("rst_pc", imem_addr, 64'h0);
        check("rst_req_after", imem_req, 1);
        out_ready = 1'b1;
        repeat (5) tick();

        // Random stalls and occasional redirects against the scoreboard
        for (int i = 0; i < 400; i++) begin
            tick();
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                redirect = 1'b1;
                redirect_pc = {32'h0, $urandom};
            end else begin
                redirect = 1'b0;
            end
        end
        tick(); redirect = 1'b0; out_ready = 1'b1;
        repeat (10) tick();

        // 16-bit PC wrap, DEPTH=2 instance
        reset2 = 1'b1;
        repeat (2) tick();
        reset2 = 1'b0; #1;
        check("wrap_first_addr", imem_addr2, 16'hFFFC);
        idx = 0;
        for (int c = 0; c < 12 && idx < 4; c++) begin
            tick(); #1;
            if (out_valid2) begin
                check("wrap_pc", out_pc2, wexp[idx]);
                check("wrap_instr", out_instr2, mem_word({48'h0, wexp[idx]}));
                idx++;
            end else if (idx > 0) begin
                check("wrap_gap", out_valid2, 1);
            end
        end
        check("wrap_done", idx, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_fetch.md
PIPELINED_FETCH -- requirements
Module: pipelined_fetch

Interface
REQ-001 Parameter ADDR_W, default 64: PC and address width.
REQ-002 Parameter INSTR_W, default 32: instruction width; PC increment is INSTR_W/8.
REQ-003 Parameter DEPTH, default 4: fetch-queue entries; power of 2, minimum 2.
REQ-004 Parameter RESET_PC, default 0: PC loaded on reset.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 redirect  input  1  branch/flush request (branch taken, BR, or BL) from later stages.
REQ-008 redirect_pc  input  ADDR_W  target PC, valid while redirect=1.
REQ-009 imem_req  output  1  instruction-memory read request this cycle.
REQ-010 imem_addr  output  ADDR_W  read address; equals the internal PC register.
REQ-011 imem_rdata  input  INSTR_W  read data, valid exactly one cycle after an accepted imem_req.
REQ-012 out_valid  output  1  queue head is valid for decode.
REQ-013 out_ready  input  1  decode accepts the head this cycle.
REQ-014 out_instr  output  INSTR_W  head instruction.
REQ-015 out_pc  output  ADDR_W  PC of the head instruction.
REQ-016 count  output  clog2(DEPTH)+1  current queue occupancy.

Function
REQ-017 pop = out_valid & out_ready; out_valid = (count != 0) & ~redirect.
REQ-018 imem_req = ~reset & ~redirect & (count + inflight - pop < DEPTH), where inflight = 1 if imem_req was asserted in the previous cycle and not cancelled, else 0.
REQ-019 When imem_req=1, the PC register advances by INSTR_W/8 at the next edge, wrapping modulo 2^ADDR_W.
REQ-020 The data returned the cycle after a request is pushed with its PC as {PC, imem_rdata}, unless redirect=1 in that return cycle, in which case it is discarded.
REQ-021 Redirect has priority over everything else: at the edge, PC <= redirect_pc with the low clog2(INSTR_W/8) bits forced to 0, the queue is emptied (count=0), and any in-flight return is discarded.
REQ-022 No pop occurs while redirect=1, because out_valid is forced low.
REQ-023 Simultaneous push and pop leave count unchanged; the queue never overflows (guaranteed by the REQ-018 credit rule) and never underflows (guaranteed by out_valid).
REQ-024 Queue pointers wrap modulo DEPTH; entries leave in FIFO order.
REQ-025 Latency: the first request for an address is made in cycle N; out_valid with that out_pc occurs in cycle N+2 at the earliest.
REQ-026 Throughput: one instruction per cycle while out_ready=1 and no redirect, for any DEPTH>=2.
REQ-027 While out_ready=0, the queue fills to DEPTH and imem_req then deasserts; out_instr and out_pc hold stable while out_valid=1 and out_ready=0.

Reset
REQ-028 While reset=1: PC=RESET_PC, count=0, inflight=0, out_valid=0, imem_req=0; all data in flight is discarded.
REQ-029 Reset asserted mid-operation overrides redirect, push and pop in the same cycle.
REQ-030 In the first cycle after reset is released: imem_req=1 and imem_addr=RESET_PC.

Verification
REQ-031 Reset release with out_ready=1 and memory word = address -> out_pc sequence 0,4,8,... starting 2 cycles after the first imem_req, one per cycle, with no gaps.
REQ-032 Hold out_ready=0 for 10 cycles -> count saturates at DEPTH and imem_req=0; then release -> DEPTH entries drain in order with no gap, and fetch resumes.
REQ-033 redirect=1 with redirect_pc=0x103 while 3 entries are queued -> out_valid=0 that cycle, count=0 next cycle, imem_addr=0x100 next cycle, and the first out_pc=0x100 with no stale entry delivered.
REQ-034 Redirect in the return cycle of a pending request -> that return is not pushed; a second redirect on the following cycle -> only the second target is delivered.
REQ-035 ADDR_W=16 with RESET_PC=0xFFFC -> out_pc sequence 0xFFFC, 0x0000 (wrap).
REQ-036 reset=1 while the queue is full and redirect=1 -> the next cycle shows count=0 and PC=RESET_PC; randomized out_ready stalls against a reference model -> every PC delivered exactly once, in order.
